mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one `mux` instance between 2**SIZE_CTRL requesters.
- Drives the mux `ctrl` select bus and returns a one-hot grant to the requesters.
- Uses a request/hold handshake with an optional forced-release timeout, so no requester can starve the others.
- Sits directly in front of the mux select; the mux data path itself is unchanged.

---
 rtl/mux_rr_arbiter_pkg.sv | 14 +
 rtl/mux_rr_arbiter_pick.sv | 38 +++
 rtl/mux_rr_arbiter.sv | 85 ++++++++
 tb/tb_mux_rr_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encodings and
// the requester-count helper.
package mux_rr_arbiter_pkg;

  // FSM state encodings (kept as plain constants for legacy tooling).
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Number of requesters sharing a mux with a select of the given width.
  function automatic int num_req(input int size_ctrl);
    return 1 << size_ctrl;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational circular priority encoder: the first set request found
// scanning upward from ptr, wrapping modulo N.
module mux_rr_arbiter_pick
  import mux_rr_arbiter_pkg::*;
#(
  parameter int SIZE_CTRL = 2
) (
  input  logic [num_req(SIZE_CTRL)-1:0] req,
  input  logic [SIZE_CTRL-1:0]          ptr,
  output logic [SIZE_CTRL-1:0]          idx,
  output logic                          any
);

  localparam int N = num_req(SIZE_CTRL);

  logic [2*N-1:0]       req_dbl;
  logic [N-1:0]         req_rot;
  logic [SIZE_CTRL-1:0] offset;

  // Rotate req right by ptr so the scan always starts at bit 0.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[N-1:0];

  // Lowest set bit of the rotated vector; scanning from the top keeps the
  // lowest match as the final assignment.
  always_comb begin
    // NOTE: defaulting every always_comb output first prevents latch inference.
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = SIZE_CTRL'(i);
    end
  end

  // Undo the rotation; natural overflow gives the modulo-N wrap.
  assign idx = offset + ptr;
  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of one shared mux. A requester
// holds the mux while its req stays high, up to MAX_HOLD cycles, then the
// priority pointer moves past it. Every output is registered.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int SIZE_CTRL = 2,
  parameter int MAX_HOLD  = 8,
  parameter int CNT_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [num_req(SIZE_CTRL)-1:0] req,
  output logic [num_req(SIZE_CTRL)-1:0] gnt,
  output logic [SIZE_CTRL-1:0]          ctrl,
  output logic                          sel_valid,
  output logic [CNT_W-1:0]              busy_cnt
);

  localparam int N = num_req(SIZE_CTRL);

  // Final count value of a tenure; unused when MAX_HOLD is 0 (unlimited).
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  logic [0:0]           state;
  logic [SIZE_CTRL-1:0] ptr;
  logic [SIZE_CTRL-1:0] win_idx;
  logic                 win_any;
  logic                 timeout;
  logic                 rel;

  mux_rr_arbiter_pick #(
    .SIZE_CTRL (SIZE_CTRL)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (win_idx),
    .any (win_any)
  );

  // Tenure ends when the owner drops req or its hold budget is spent.
  assign timeout = (MAX_HOLD != 0) && (busy_cnt == HOLD_LAST);
  assign rel     = ~req[ctrl] | timeout;

  // FSM, hold counter, priority pointer and registered mux-select outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      ctrl      <= '0;
      sel_valid <= 1'b0;
      busy_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          // ctrl is left alone with no request so the mux select never toggles.
          if (win_any) begin
            gnt       <= N'(1) << win_idx;
            ctrl      <= win_idx;
            sel_valid <= 1'b1;
            busy_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            // The released owner drops to lowest priority; ctrl holds.
            gnt       <= '0;
            sel_valid <= 1'b0;
            busy_cnt  <= '0;
            ptr       <= ctrl + 1'b1;
            state     <= IDLE;
          end else begin
            busy_cnt  <= busy_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset behaviour, a table of
// single-cycle vectors, then timeout and strict round-robin sequences.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] ctrl;
  logic       sel_valid;
  logic [3:0] busy_cnt;

  logic [3:0] req1;
  logic [3:0] gnt1;
  logic [1:0] ctrl1;
  logic       sel_valid1;
  logic [3:0] busy_cnt1;

  logic [3:0] mux_in;
  logic       mux_out;

  int n_pass;
  int n_total;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] ctrl;
    logic       valid;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [19];

  mux_rr_arbiter #(.SIZE_CTRL(2), .MAX_HOLD(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .ctrl      (ctrl),
    .sel_valid (sel_valid),
    .busy_cnt  (busy_cnt)
  );

  mux_rr_arbiter #(.SIZE_CTRL(2), .MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req1),
    .gnt       (gnt1),
    .ctrl      (ctrl1),
    .sel_valid (sel_valid1),
    .busy_cnt  (busy_cnt1)
  );

  // Shared mux driven by the arbiter select.
  assign mux_out = mux_in[ctrl];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_main(input string tag, input logic [3:0] g, input logic [1:0] c,
                             input logic v, input logic [3:0] n);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    check({tag, ".valid"}, 32'(sel_valid), 32'(v));
    check({tag, ".cnt"}, 32'(busy_cnt), 32'(n));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    mux_in  = 4'b0101;
    req     = 4'b0000;
    req1    = 4'b0000;
    rst_n   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    expect_main("reset", 4'b0000, 2'd0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Grant requester 1, then reset mid-tenure with no clock edge.
    req = 4'b0010;
    tick();
    expect_main("pre_rst", 4'b0010, 2'd1, 1'b1, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_main("async_rst", 4'b0000, 2'd0, 1'b0, 4'd0);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    tick();
    expect_main("post_rst", 4'b0000, 2'd0, 1'b0, 4'd0);

    // Vector table: req applied before the edge, outputs expected after it.
    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'd0};  // single requester
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'd1};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'd2};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 4'd0};  // drop, ptr=3
    tbl[5]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 4'd0};  // wrap: 0 beats 1
    tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0};  // ptr=1
    tbl[7]  = '{4'b0011, 4'b0010, 2'd1, 1'b1, 4'd0};  // now 1 wins
    tbl[8]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 4'd1};  // req[3] ignored
    tbl[9]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 4'd2};
    tbl[10] = '{4'b1010, 4'b0010, 2'd1, 1'b1, 4'd3};
    tbl[11] = '{4'b0000, 4'b0000, 2'd1, 1'b0, 4'd0};  // ptr=2
    tbl[12] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 4'd0};  // 2,3 empty -> 0
    tbl[13] = '{4'b1001, 4'b0001, 2'd0, 1'b1, 4'd1};
    tbl[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0};  // ptr=1
    tbl[15] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'd0};
    tbl[16] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'd1};
    tbl[17] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 4'd0};  // ptr wraps to 0
    tbl[18] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 4'd0};  // idle holds ctrl

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      req = tbl[i].req;
      tick();
      expect_main($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].ctrl, tbl[i].valid, tbl[i].cnt);
      check($sformatf("vec%0d.mux", i), 32'(mux_out), 32'(mux_in[tbl[i].ctrl]));
    end

    // Timeout: req=0011 held, 8-cycle tenures alternating 0,1,0 with one idle gap.
    @(negedge clk);
    req = 4'b0011;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        expect_main($sformatf("to%0d_%0d", t, c), 4'(1 << (t % 2)), 2'(t % 2), 1'b1, 4'(c));
      end
      if (t < 2) begin
        tick();
        expect_main($sformatf("to%0d_idle", t), 4'b0000, 2'(t % 2), 1'b0, 4'd0);
      end
    end
    @(negedge clk);
    req = 4'b0000;
    tick();
    expect_main("to_end", 4'b0000, 2'd0, 1'b0, 4'd0);

    // Strict round robin with MAX_HOLD=1: grant, idle, next grant.
    @(negedge clk);
    req1 = 4'b1111;
    for (int g = 0; g < 9; g++) begin
      tick();
      check($sformatf("rr%0d.gnt", g), 32'(gnt1),
            (g % 2 == 0) ? 32'(1 << ((g / 2) % 4)) : 32'd0);
      check($sformatf("rr%0d.ctrl", g), 32'(ctrl1), 32'((g / 2) % 4));
      check($sformatf("rr%0d.valid", g), 32'(sel_valid1), 32'(g % 2 == 0));
      check($sformatf("rr%0d.cnt", g), 32'(busy_cnt1), 32'd0);
    end
    @(negedge clk);
    req1 = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
